// File: rtl/spi_feeder_pkg.sv
// Shared types and constants for the SPI frame feeder: device select
// encoding, FSM states and the latched frame request.
package spi_feeder_pkg;

    localparam int unsigned SIZE_W_DEFAULT = 13;
    localparam int unsigned NBYTES_W       = 10;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BIT_CNT_W      = 3;

    typedef enum logic [1:0] {
        DEV_FLASH = 2'd0,
        DEV_SHREG = 2'd1,
        DEV_MPU   = 2'd2,
        DEV_RSVD  = 2'd3
    } dev_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } feeder_state_e;

    typedef struct packed {
        dev_sel_e              dev;
        logic [NBYTES_W-1:0]   nbytes;
        logic                  nrw;
    } frame_req_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO with registered full/empty flags and a synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_byte_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_c,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_c  = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // A push coinciding with a flush is discarded along with the contents.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
        end else begin
            count_q <= count_d;
            full_o  <= (count_d == CW'(DEPTH));
            empty_o <= (count_d == '0);
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_frame_feeder.sv
// Feeds queued bytes MSB-first to an SPI master, framing them with a chip select.
// Optional SPI_FEEDER_ABORT_EN adds abort_i to cancel a frame and flush the FIFO.
module spi_frame_feeder
    import spi_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SIZE_W     = SIZE_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [1:0]          dev_sel_i,
    input  logic [NBYTES_W-1:0] nbytes_i,
    input  logic                nrw_i,
    input  logic [BYTE_W-1:0]   byte_i,
    input  logic                byte_valid_i,
    output logic                byte_ready_o,
    output logic                cs_flash_o,
    output logic                cs_shift_reg_o,
    output logic                cs_mpu_o,
    output logic [SIZE_W-1:0]   data_size_o,
    output logic                master_mode_nrw_o,
    output logic                mosi_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                underrun_o
`ifdef SPI_FEEDER_ABORT_EN
    ,
    input  logic                abort_i
`endif
);

    feeder_state_e          state_q, state_d;
    frame_req_t             req_q, req_d;
    logic [NBYTES_W-1:0]    left_q, left_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      shreg_q, shreg_d;
    logic                   mosi_d;
    logic                   done_d;
    logic                   underrun_d;
    logic                   pop_c;
    logic                   flush_c;
    logic [BYTE_W-1:0]      fifo_head_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    spi_byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (BYTE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_c),
        .push_i  (byte_valid_i),
        .data_i  (byte_i),
        .pop_i   (pop_c),
        .head_c  (fifo_head_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign byte_ready_o = !fifo_full;

    // Next-state and next-output logic; left_q counts bytes not yet popped.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        left_d     = left_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        mosi_d     = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        pop_c      = 1'b0;
        flush_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && (nbytes_i != '0) && (dev_sel_e'(dev_sel_i) != DEV_RSVD)) begin
                    req_d.dev    = dev_sel_e'(dev_sel_i);
                    req_d.nbytes = nbytes_i;
                    req_d.nrw    = nrw_i;
                    left_d       = nbytes_i;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    shreg_d   = fifo_head_c;
                    mosi_d    = fifo_head_c[BYTE_W-1];
                    left_d    = left_q - NBYTES_W'(1);
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != BIT_CNT_W'(BYTE_W - 1)) begin
                    shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                    mosi_d    = shreg_q[BYTE_W-2];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end else if (left_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    // Back-to-back reload keeps the chip select continuous.
                    pop_c     = 1'b1;
                    shreg_d   = fifo_head_c;
                    mosi_d    = fifo_head_c[BYTE_W-1];
                    left_d    = left_q - NBYTES_W'(1);
                    bit_cnt_d = '0;
                end else begin
                    underrun_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SPI_FEEDER_ABORT_EN
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            pop_c      = 1'b0;
            flush_c    = 1'b1;
            mosi_d     = 1'b0;
            done_d     = 1'b0;
            underrun_d = 1'b0;
        end
`endif
    end

    // State register; outputs are registered from the next-state values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= ST_IDLE;
            req_q             <= '0;
            left_q            <= '0;
            bit_cnt_q         <= '0;
            shreg_q           <= '0;
            cs_flash_o        <= 1'b0;
            cs_shift_reg_o    <= 1'b0;
            cs_mpu_o          <= 1'b0;
            data_size_o       <= '0;
            master_mode_nrw_o <= 1'b0;
            mosi_o            <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            underrun_o        <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            left_q            <= left_d;
            bit_cnt_q         <= bit_cnt_d;
            shreg_q           <= shreg_d;
            cs_flash_o        <= (state_d == ST_SHIFT) && (req_d.dev == DEV_FLASH);
            cs_shift_reg_o    <= (state_d == ST_SHIFT) && (req_d.dev == DEV_SHREG);
            cs_mpu_o          <= (state_d == ST_SHIFT) && (req_d.dev == DEV_MPU);
            data_size_o       <= (state_d == ST_SHIFT) ? SIZE_W'({req_d.nbytes, 3'b000}) : '0;
            master_mode_nrw_o <= (state_d == ST_SHIFT) && req_d.nrw;
            mosi_o            <= mosi_d;
            busy_o            <= (state_d != ST_IDLE);
            done_o            <= done_d;
            underrun_o        <= underrun_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_feeder.sv
// Directed, table-driven bench for spi_frame_feeder: frame vectors plus
// hand-written FIFO backpressure, ignored-start and mid-frame reset sequences.
module tb_spi_frame_feeder;
    import spi_feeder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  dev_sel_i;
    logic [9:0]  nbytes_i;
    logic        nrw_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        cs_flash_o;
    logic        cs_shift_reg_o;
    logic        cs_mpu_o;
    logic [12:0] data_size_o;
    logic        master_mode_nrw_o;
    logic        mosi_o;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;
`ifdef SPI_FEEDER_ABORT_EN
    logic        abort_i = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    spi_frame_feeder #(
        .FIFO_DEPTH (4),
        .SIZE_W     (13)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .start_i           (start_i),
        .dev_sel_i         (dev_sel_i),
        .nbytes_i          (nbytes_i),
        .nrw_i             (nrw_i),
        .byte_i            (byte_i),
        .byte_valid_i      (byte_valid_i),
        .byte_ready_o      (byte_ready_o),
        .cs_flash_o        (cs_flash_o),
        .cs_shift_reg_o    (cs_shift_reg_o),
        .cs_mpu_o          (cs_mpu_o),
        .data_size_o       (data_size_o),
        .master_mode_nrw_o (master_mode_nrw_o),
        .mosi_o            (mosi_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .underrun_o        (underrun_o)
`ifdef SPI_FEEDER_ABORT_EN
        ,
        .abort_i           (abort_i)
`endif
    );

    typedef struct packed {
        logic [1:0]  dev;
        logic [9:0]  nbytes;
        logic        nrw;
        logic [3:0]  npre;
        logic [63:0] data;
        logic [9:0]  exp_cs;
        logic        exp_done;
        logic        exp_und;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string name);
        check({name, " outputs"}, 32'({cs_flash_o, cs_shift_reg_o, cs_mpu_o, master_mode_nrw_o,
                                       mosi_o, busy_o, done_o, underrun_o, data_size_o}), 32'd0);
        check({name, " byte_ready"}, 32'(byte_ready_o), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] dev, input logic [9:0] nb, input logic nrw);
        start_i   = 1'b1;
        dev_sel_i = dev;
        nbytes_i  = nb;
        nrw_i     = nrw;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    function automatic logic sel_cs(input logic [1:0] dev);
        case (dev)
            2'd0:    return cs_flash_o;
            2'd1:    return cs_shift_reg_o;
            2'd2:    return cs_mpu_o;
            default: return 1'b0;
        endcase
    endfunction

    // Observe one frame from the current negedge until done/underrun or a cycle budget.
    task automatic watch_frame(input string name, input logic [1:0] dev, input logic [9:0] nb,
                               input logic nrw, input logic [63:0] stream, input int exp_cs,
                               input bit exp_done, input bit exp_und);
        int cs_cnt = 0, bit_err = 0, attr_err = 0, idle_err = 0, gap = 0, edge_err = 0;
        int cs_sum, limit;
        bit fell = 0, prev = 0, fin = 0, done_seen = 0, und_seen = 0;
        logic s;
        logic [12:0] exp_size;
        exp_size = 13'({nb, 3'b000});
        limit    = 8 * int'(nb) + 40;
        for (int cyc = 0; cyc < limit && !fin; cyc++) begin
            s      = sel_cs(dev);
            cs_sum = int'(cs_flash_o) + int'(cs_shift_reg_o) + int'(cs_mpu_o);
            if (cs_sum > (s ? 1 : 0)) attr_err++;
            if (s) begin
                if (fell) gap++;
                if (cs_cnt < 64 && mosi_o !== stream[63-cs_cnt]) bit_err++;
                if (data_size_o !== exp_size || master_mode_nrw_o !== nrw || busy_o !== 1'b1) attr_err++;
                cs_cnt++;
            end else begin
                if (prev) fell = 1;
                if (mosi_o !== 1'b0 || data_size_o !== '0 || master_mode_nrw_o !== 1'b0) idle_err++;
            end
            if (done_o || underrun_o) begin
                fin       = 1;
                done_seen = done_o;
                und_seen  = underrun_o;
                if (!prev || busy_o) edge_err++;
            end
            prev = s;
            if (!fin) @(negedge clk_i);
        end
        check({name, " finished"}, 32'(fin), 32'd1);
        check({name, " cs cycles"}, 32'(cs_cnt), 32'(exp_cs));
        check({name, " mosi bit errors"}, 32'(bit_err), 32'd0);
        check({name, " cs/size/nrw errors"}, 32'(attr_err), 32'd0);
        check({name, " idle output errors"}, 32'(idle_err), 32'd0);
        check({name, " cs gaps"}, 32'(gap), 32'd0);
        check({name, " pulse alignment errors"}, 32'(edge_err), 32'd0);
        check({name, " done"}, 32'(done_seen), 32'(exp_done));
        check({name, " underrun"}, 32'(und_seen), 32'(exp_und));
        @(negedge clk_i);
        check({name, " pulses after"}, 32'({done_o, underrun_o, busy_o}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{dev: 2'd0, nbytes: 10'd1, nrw: 1'b1, npre: 4'd1, data: 64'h0600000000000000,
                    exp_cs: 10'd8,  exp_done: 1'b1, exp_und: 1'b0};
        vecs[1] = '{dev: 2'd1, nbytes: 10'd4, nrw: 1'b0, npre: 4'd4, data: 64'h02AAAAAA00000000,
                    exp_cs: 10'd32, exp_done: 1'b1, exp_und: 1'b0};
        vecs[2] = '{dev: 2'd2, nbytes: 10'd2, nrw: 1'b1, npre: 4'd1, data: 64'hC300000000000000,
                    exp_cs: 10'd8,  exp_done: 1'b0, exp_und: 1'b1};
        vecs[3] = '{dev: 2'd2, nbytes: 10'd3, nrw: 1'b0, npre: 4'd3, data: 64'h817EFF0000000000,
                    exp_cs: 10'd24, exp_done: 1'b1, exp_und: 1'b0};

        rst_ni       = 1'b0;
        start_i      = 1'b0;
        dev_sel_i    = 2'd0;
        nbytes_i     = 10'd0;
        nrw_i        = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_outs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Frame vectors
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < int'(vecs[i].npre); j++) push_byte(vecs[i].data[63-8*j -: 8]);
            start_frame(vecs[i].dev, vecs[i].nbytes, vecs[i].nrw);
            watch_frame($sformatf("vec%0d", i), vecs[i].dev, vecs[i].nbytes, vecs[i].nrw,
                        vecs[i].data, int'(vecs[i].exp_cs), vecs[i].exp_done, vecs[i].exp_und);
        end

        // FIFO backpressure: 4 pushes fill it, 5th waits for the first pop
        byte_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_i = 8'(8'h11 * (i + 1));
            @(negedge clk_i);
            check($sformatf("fill ready after push %0d", i + 1), 32'(byte_ready_o), (i < 3) ? 32'd1 : 32'd0);
        end
        byte_i = 8'h5A;
        @(negedge clk_i);
        check("full ready held low", 32'(byte_ready_o), 32'd0);
        start_i   = 1'b1;
        dev_sel_i = 2'd0;
        nbytes_i  = 10'd5;
        nrw_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        fork
            watch_frame("five bytes", 2'd0, 10'd5, 1'b1, 64'h112233445A000000, 40, 1'b1, 1'b0);
            begin
                check("ready before pop", 32'(byte_ready_o), 32'd0);
                @(negedge clk_i);
                check("ready after pop", 32'(byte_ready_o), 32'd1);
                @(negedge clk_i);
                check("ready after 5th push", 32'(byte_ready_o), 32'd0);
                byte_valid_i = 1'b0;
            end
        join

        // Ignored starts: nbytes 0, reserved device, and start during SHIFT
        push_byte(8'h3C);
        start_frame(2'd0, 10'd0, 1'b0);
        check("nbytes0 busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check("nbytes0 busy later", 32'({busy_o, done_o, underrun_o}), 32'd0);
        start_frame(2'd3, 10'd1, 1'b0);
        check("dev3 busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check("dev3 busy later", 32'({busy_o, done_o, underrun_o}), 32'd0);
        start_frame(2'd0, 10'd1, 1'b0);
        watch_frame("byte kept", 2'd0, 10'd1, 1'b0, 64'h3C00000000000000, 8, 1'b1, 1'b0);

        push_byte(8'hF0);
        start_frame(2'd1, 10'd1, 1'b0);
        fork
            watch_frame("start in shift", 2'd1, 10'd1, 1'b0, 64'hF000000000000000, 8, 1'b1, 1'b0);
            begin
                repeat (3) @(negedge clk_i);
                start_i   = 1'b1;
                dev_sel_i = 2'd2;
                nbytes_i  = 10'd1;
                nrw_i     = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
        join
        @(negedge clk_i);
        check("no frame from shift start", 32'(busy_o), 32'd0);

        // Reset mid-SHIFT
        push_byte(8'hAA);
        push_byte(8'h55);
        start_frame(2'd2, 10'd2, 1'b1);
        repeat (5) @(negedge clk_i);
        check("mid-frame cs", 32'(cs_mpu_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1 check_reset_outs("async reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outs("after reset");
        start_frame(2'd0, 10'd1, 1'b0);
        repeat (3) @(negedge clk_i);
        check("waits on empty fifo", 32'({busy_o, cs_flash_o}), 32'b10);
        push_byte(8'h99);
        watch_frame("post reset", 2'd0, 10'd1, 1'b0, 64'h9900000000000000, 8, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
